// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider_pkg
// Description : FSM state encoding and reset values shared by the sequential
//               divider. The FIX state exists only when SEQ_DIVIDER_SIGNED_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

  // Raw state codes, kept as plain constants for legacy tools
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam logic [1:0] S_FIX  = 2'd2;
`endif
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CALC = S_CALC,
`ifdef SEQ_DIVIDER_SIGNED_EN
    ST_FIX  = S_FIX,
`endif
    ST_DONE = S_DONE
  } state_e;

  // Values forced by reset
  localparam state_e RST_STATE = ST_IDLE;
  localparam logic   RST_FLAG  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/subtractor_nbits.sv
`default_nettype none
// ============================================================================
// Module      : subtractor_nbits
// Description : Unsigned a - b with borrow-out; used for the trial
//               subtraction of the restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
module subtractor_nbits #(
  parameter int width = 5
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] d_o,
  output logic             borrow_o
);

  // One extra bit catches the borrow: it is set exactly when b_i > a_i
  assign {borrow_o, d_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Multi-cycle restoring divider, one quotient bit per cycle,
//               MSB first. Divide-by-zero finishes in one cycle with
//               quotient = all ones, remainder = dividend.
//               Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement
//               operands, magnitudes divided in CALC, signs applied in an
//               extra FIX cycle (quotient truncates toward zero, remainder
//               follows the dividend sign).
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [width-1:0] dividend_i,
  input  logic [width-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [width-1:0] quotient_o,
  output logic [width-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(width);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(width - 1);

  state_e             state_q, state_d;
  logic [width-1:0]   prem_q, prem_d;   // partial remainder (always < divisor)
  logic [width-1:0]   acc_q, acc_d;     // dividend bits shift out, quotient bits shift in
  logic [width-1:0]   dvs_q, dvs_d;     // captured divisor magnitude
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [width-1:0]   quo_q, quo_d;
  logic [width-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic               negq_q, negq_d;   // quotient must be negated
  logic               negr_q, negr_d;   // remainder must be negated
`endif

  logic [width-1:0]   dvd_mag;
  logic [width-1:0]   dvs_mag;
  logic [width:0]     shifted;
  logic [width:0]     diff;
  logic               borrow;
  logic               unused_diff_msb;
  logic [width-1:0]   calc_prem;
  logic [width-1:0]   calc_acc;

`ifdef SEQ_DIVIDER_SIGNED_EN
  // Magnitudes; the most negative value maps to 2^(width-1), which still fits
  assign dvd_mag = dividend_i[width-1] ? -dividend_i : dividend_i;
  assign dvs_mag = divisor_i[width-1]  ? -divisor_i  : divisor_i;
`else
  assign dvd_mag = dividend_i;
  assign dvs_mag = divisor_i;
`endif

  // Shift the next dividend bit into the partial remainder, then trial-subtract
  assign shifted = {prem_q, acc_q[width-1]};

  subtractor_nbits #(
    .width (width + 1)
  ) u_sub (
    .a_i      (shifted),
    .b_i      ({1'b0, dvs_q}),
    .d_o      (diff),
    .borrow_o (borrow)
  );

  // When no borrow occurs the difference is below the divisor, so its MSB is 0
  assign unused_diff_msb = diff[width];

  assign calc_prem = borrow ? shifted[width-1:0] : diff[width-1:0];
  assign calc_acc  = {acc_q[width-2:0], ~borrow};

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    negq_d  = negq_q;
    negr_d  = negr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          prem_d = '0;
          acc_d  = dvd_mag;
          dvs_d  = dvs_mag;
          cnt_d  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
          negq_d = dividend_i[width-1] ^ divisor_i[width-1];
          negr_d = dividend_i[width-1];
`endif
          if (divisor_i == '0) begin
            state_d = ST_DONE;
            quo_d   = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        prem_d = calc_prem;
        acc_d  = calc_acc;
        if (cnt_q == LAST_STEP) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = ST_FIX;
`else
          state_d = ST_DONE;
          quo_d   = calc_acc;
          rem_d   = calc_prem;
          dbz_d   = 1'b0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      ST_FIX: begin
        // min / -1 yields magnitude 2^(width-1), which reads back as min
        state_d = ST_DONE;
        quo_d   = negq_q ? -acc_q  : acc_q;
        rem_d   = negr_q ? -prem_q : prem_q;
        dbz_d   = 1'b0;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over any pending request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      prem_q  <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= RST_FLAG;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      negq_q  <= negq_d;
      negr_q  <= negr_d;
`endif
    end
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  assign busy_o = (state_q == ST_CALC) || (state_q == ST_FIX);
`else
  assign busy_o = (state_q == ST_CALC);
`endif
  assign done_o        = (state_q == ST_DONE);
  assign quotient_o    = quo_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Bench for seq_divider (width 4). A cycle-level reference
//               model computes expected outputs from plain arithmetic; a
//               negedge process compares every cycle. Directed operations
//               pin known results, then random traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int W = 4;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int BUSY_CYCLES = W + 1;
`else
  localparam int BUSY_CYCLES = W;
`endif
  localparam int DONE_LAT = BUSY_CYCLES + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dvd;
  logic [W-1:0] dvs;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_by_zero_o;

  always #5 clk = ~clk;

  seq_divider #(
    .width (W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dvd),
    .divisor_i     (dvs),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .quotient_o    (quotient_o),
    .remainder_o   (remainder_o),
    .div_by_zero_o (div_by_zero_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    int ia, ib;
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      ia = $signed(a);
      ib = $signed(b);
`else
      ia = int'(a);
      ib = int'(b);
`endif
      q = W'(ia / ib);
      r = W'(ia % ib);
      z = 1'b0;
    end
  endfunction

  // Cycle-level model: what the outputs must be after each rising edge
  bit           model_ok = 0;
  bit           active   = 0;
  int           left     = 0;
  logic         exp_busy, exp_done, exp_dbz, pend_dbz;
  logic [W-1:0] exp_q, exp_r, pend_q, pend_r;

  always @(posedge clk) begin
    if (rst) begin
      model_ok = 1;
      active   = 0;
      exp_busy = 1'b0;
      exp_done = 1'b0;
      exp_q    = '0;
      exp_r    = '0;
      exp_dbz  = 1'b0;
    end else if (model_ok) begin
      if (active) begin
        if (left > 0) begin
          left--;
        end else begin
          active   = 0;
          exp_busy = 1'b0;
          exp_done = 1'b1;
          exp_q    = pend_q;
          exp_r    = pend_r;
          exp_dbz  = pend_dbz;
        end
      end else if (exp_done) begin
        exp_done = 1'b0;
      end else if (start) begin
        ref_div(dvd, dvs, pend_q, pend_r, pend_dbz);
        if (dvs == '0) begin
          exp_done = 1'b1;
          exp_q    = pend_q;
          exp_r    = pend_r;
          exp_dbz  = pend_dbz;
        end else begin
          active   = 1;
          exp_busy = 1'b1;
          left     = BUSY_CYCLES - 1;
        end
      end
    end
  end

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (model_ok) begin
      check("busy",  W'(busy_o),        W'(exp_busy));
      check("done",  W'(done_o),        W'(exp_done));
      check("quot",  quotient_o,        exp_q);
      check("rem",   remainder_o,       exp_r);
      check("dbz",   W'(div_by_zero_o), W'(exp_dbz));
    end
  end

  // Directed op with literal expectations; optional ignored start at T+2
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int exp_lat,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                    input bit inject, input string tag);
    int lat;
    int extra;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    dvd   = a;
    dvs   = b;
    lat   = 0;
    seen  = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = done_o;
      if (inject && lat == 2) begin
        start = 1'b1;
        dvd   = 4'd9;
        dvs   = 4'd2;
      end else begin
        start = 1'b0;
        dvd   = W'($urandom);
        dvs   = W'($urandom);
      end
    end
    check_int({tag, "_latency"}, lat, exp_lat);
    check({tag, "_q"}, quotient_o, eq);
    check({tag, "_r"}, remainder_o, er);
    check({tag, "_z"}, W'(div_by_zero_o), W'(ez));
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check_int({tag, "_extra_done"}, extra, 0);
    check({tag, "_q_held"}, quotient_o, eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra;
    rst   = 1'b1;
    start = 1'b1;
    dvd   = 4'd5;
    dvs   = 4'd1;
    repeat (2) @(negedge clk);
    check("reset_busy", W'(busy_o), '0);
    check("reset_done", W'(done_o), '0);
    check("reset_q", quotient_o, '0);
    check("reset_r", remainder_o, '0);
    check("reset_z", W'(div_by_zero_o), '0);
    rst   = 1'b0;
    start = 1'b0;

`ifdef SEQ_DIVIDER_SIGNED_EN
    op(4'b1001, 4'd2,    DONE_LAT, 4'b1101, 4'b1111, 1'b0, 0, "neg7_2");
    op(4'b1000, 4'b1111, DONE_LAT, 4'b1000, 4'b0000, 1'b0, 0, "min_m1");
    op(4'd7,    4'd0,    1,        4'b1111, 4'd7,    1'b1, 0, "div0");
    op(4'd6,    4'd4,    DONE_LAT, 4'd1,    4'd2,    1'b0, 0, "six_four");
`else
    op(4'd13, 4'd3, DONE_LAT, 4'd4,  4'd1, 1'b0, 0, "thirteen_3");
    op(4'd7,  4'd0, 1,        4'd15, 4'd7, 1'b1, 0, "div0");
    op(4'd15, 4'd1, DONE_LAT, 4'd15, 4'd0, 1'b0, 0, "fifteen_1");
    op(4'd13, 4'd3, DONE_LAT, 4'd4,  4'd1, 1'b0, 1, "start_ignored");
`endif

    // Abort mid-calculation with reset
    @(negedge clk);
    start = 1'b1;
    dvd   = 4'd13;
    dvs   = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", W'(busy_o), '0);
    check("abort_done", W'(done_o), '0);
    check("abort_q", quotient_o, '0);
    check("abort_r", remainder_o, '0);
    extra = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    check_int("abort_no_done", extra, 0);
    op(4'd6, 4'd4, DONE_LAT, 4'd1, 4'd2, 1'b0, 0, "after_abort");

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      rst   = ($urandom_range(0, 59) == 0);
      start = ($urandom_range(0, 2) == 0);
      dvd   = W'($urandom);
      case ($urandom_range(0, 7))
        0:       dvs = '0;
        1:       begin dvd = 4'b1000; dvs = 4'b1111; end
        default: dvs = W'($urandom);
      endcase
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter: width, default 4, operand/result bit width (minimum 2).
REQ-002 SHALL have port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start_i  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port: dividend_i  input  width  dividend, captured when a request is accepted.
REQ-006 SHALL have port: divisor_i  input  width  divisor, captured when a request is accepted.
REQ-007 SHALL have port: busy_o  output  1  high while the iteration is in progress.
REQ-008 SHALL have port: done_o  output  1  one-cycle pulse when results become valid.
REQ-009 SHALL have port: quotient_o  output  width  quotient, held until the next accepted request.
REQ-010 SHALL have port: remainder_o  output  width  remainder, held until the next accepted request.
REQ-011 SHALL have port: div_by_zero_o  output  1  flag for the last result, held with the results.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX (present only with the macro), DONE.
REQ-013 SHALL accept a request in cycle T only when in IDLE with start_i=1; operands are captured at T.
REQ-014 SHALL ignore start_i in CALC, FIX and DONE; operand changes after T SHALL have no effect.
REQ-015 SHALL perform restoring division (unsigned without the macro):
- one quotient bit per CALC cycle, MSB first;
- width+1-bit partial remainder, shift left, trial subtract divisor;
- keep the difference and set the quotient bit on no-borrow, otherwise restore.
REQ-016 SHALL stay in CALC for exactly width cycles, T+1..T+width, with busy_o=1.
REQ-017 SHALL enter DONE at T+width+1 with done_o=1 for that cycle only, then return to IDLE.
REQ-018 SHALL update quotient_o and remainder_o on entry to DONE; they SHALL be stable until the next DONE.
REQ-019 SHALL handle divisor=0 at acceptance as follows:
- go IDLE->DONE directly, done_o at T+1;
- quotient_o=all ones, remainder_o=dividend, div_by_zero_o=1.
REQ-020 SHALL clear div_by_zero_o on any non-zero-divisor result.
REQ-021 SHALL give busy_o and done_o as pure decodes of the state register (no combinational path from inputs).
REQ-022 SHALL guarantee quotient*divisor+remainder=dividend with remainder<divisor for every non-zero divisor.

Reset
REQ-023 SHALL, when rst_i=1 at a clock edge, force IDLE and set busy_o=0, done_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0.
REQ-024 SHALL make reset take priority over start_i in the same cycle.
REQ-025 SHALL make reset in CALC abort the operation with no done_o pulse.

Configuration
REQ-026 SHALL support macro SEQ_DIVIDER_SIGNED_EN.
REQ-027 SHALL, when SEQ_DIVIDER_SIGNED_EN is defined:
- treat operands as two's complement;
- divide the magnitudes in CALC;
- apply signs in FIX (1 cycle, busy_o=1), so done_o is at T+width+2;
- truncate the quotient toward zero; the remainder takes the sign of the dividend;
- give min/-1 quotient=min, remainder=0;
- handle divide-by-zero as in REQ-019, done_o at T+1.
REQ-028 SHALL, when SEQ_DIVIDER_SIGNED_EN is undefined, implement unsigned-only operation with no FIX state and latency per REQ-017.

Structure
REQ-029 SHALL place the FSM state enum typedef and reset-value constants in package seq_divider_pkg.
REQ-030 SHALL compute the trial subtraction in sub-module subtractor_nbits (parameter width):
- ports a_i, b_i, d_o, borrow_o;
- instantiated once at width+1 bits.

Verification (width=4)
REQ-031 SHALL cover: 13/3 accepted at T -> busy_o T+1..T+4, done_o at T+5, quotient=4, remainder=1, div_by_zero_o=0.
REQ-032 SHALL cover: 7/0 -> done_o at T+1, quotient=15, remainder=7, div_by_zero_o=1; next 15/1 -> quotient=15, remainder=0, flag cleared.
REQ-033 SHALL cover: start_i=1 with 9/2 at T+2 during 13/3 -> ignored; result 4/1 unchanged; no second done_o.
REQ-034 SHALL cover: rst_i=1 at T+2 of 13/3 -> IDLE next cycle, all outputs 0, no done_o; a new 6/4 then gives quotient=1, remainder=2.
REQ-035 SHALL cover, with SEQ_DIVIDER_SIGNED_EN: -7/2 -> done_o at T+6, quotient=4'b1101, remainder=4'b1111; -8/-1 -> quotient=4'b1000, remainder=0.
